mem_access_unit: RTL and testbench

//  Load/store stage downstream of the register file. Takes ROA (address) and ROD (store data) plus a

---
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: runs one word transaction on the core memory bus per request,
// with a bounded wait that ends the transaction in error if the bus never responds.
module mem_access_unit #(
  parameter int WORD_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [WORD_WIDTH-1:0] addr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  output logic                  req_ready_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  bus_valid_o,
  output logic                  bus_we_o,
  output logic [WORD_WIDTH-1:0] bus_addr_o,
  output logic [WORD_WIDTH-1:0] bus_wdata_o,
  input  logic                  bus_ready_i,
  input  logic [WORD_WIDTH-1:0] bus_rdata_i,
  input  logic                  bus_err_i
);

  localparam int TO_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_WIDTH-1:0] CNT_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [WORD_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                  error_q, error_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath update; error_q is only ever set on entry to DONE
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (req_valid_i) begin
          state_d = ST_BUS;
          we_d    = req_write_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (bus_ready_i) begin
          state_d = ST_DONE;
          error_d = bus_err_i;
          if (!we_q && !bus_err_i) begin
            rdata_d = bus_rdata_i;
          end else begin
            rdata_d = rdata_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          error_d = 1'b1;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    req_ready_o = (state_q == ST_IDLE) || (state_q == ST_DONE);
    busy_o      = (state_q == ST_BUS);
    bus_valid_o = (state_q == ST_BUS);
    done_o      = (state_q == ST_DONE);
    error_o     = error_q && (state_q == ST_DONE);
    rdata_o     = rdata_q;
    bus_we_o    = we_q;
    bus_addr_o  = addr_q;
    bus_wdata_o = wdata_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES=4 so the timeout is reachable).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic        req_ready, done, error, busy, bus_valid, bus_we;
  logic [15:0] rdata, bus_addr, bus_wdata;
  logic        bus_ready = 1'b0;
  logic [15:0] bus_rdata = 16'h0000;
  logic        bus_err = 1'b0;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.WORD_WIDTH(16), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .addr_i(addr), .wdata_i(wdata), .req_ready_o(req_ready), .done_o(done),
    .error_o(error), .rdata_o(rdata), .busy_o(busy), .bus_valid_o(bus_valid),
    .bus_we_o(bus_we), .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata),
    .bus_ready_i(bus_ready), .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    // Power-up reset
    step(); step();
    rst = 1'b0;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(bus_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_rdata", 32'(rdata), 32'h0);

    // Zero-wait load
    req_valid = 1'b1; req_write = 1'b0; addr = 16'h0040;
    bus_ready = 1'b1; bus_rdata = 16'hBEEF;
    step();
    req_valid = 1'b0;
    check("ld_valid", 32'(bus_valid), 32'd1);
    check("ld_we", 32'(bus_we), 32'd0);
    check("ld_addr", 32'(bus_addr), 32'h0040);
    check("ld_ready", 32'(req_ready), 32'd0);
    check("ld_busy", 32'(busy), 32'd1);
    check("ld_done_early", 32'(done), 32'd0);
    step();
    check("ld_done", 32'(done), 32'd1);
    check("ld_error", 32'(error), 32'd0);
    check("ld_rdata", 32'(rdata), 32'hBEEF);
    check("ld_valid_drop", 32'(bus_valid), 32'd0);
    check("ld_busy_done", 32'(busy), 32'd0);
    step();
    check("ld_done_once", 32'(done), 32'd0);
    check("ld_idle_ready", 32'(req_ready), 32'd1);

    // Store with three wait cycles, ready on the fourth bus cycle
    bus_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; addr = 16'h0010; wdata = 16'h1234;
    step();
    req_valid = 1'b0; addr = 16'hFFFF; wdata = 16'hFFFF; req_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("st_valid", 32'(bus_valid), 32'd1);
      check("st_we", 32'(bus_we), 32'd1);
      check("st_addr", 32'(bus_addr), 32'h0010);
      check("st_wdata", 32'(bus_wdata), 32'h1234);
      check("st_no_done", 32'(done), 32'd0);
      if (i == 3) bus_ready = 1'b1;
      else bus_ready = 1'b0;
      step();
    end
    bus_ready = 1'b0;
    check("st_done", 32'(done), 32'd1);
    check("st_error", 32'(error), 32'd0);
    check("st_rdata_kept", 32'(rdata), 32'hBEEF);
    step();
    check("st_done_once", 32'(done), 32'd0);

    // Timeout: four cycles of valid, then done with error
    req_valid = 1'b1; req_write = 1'b0; addr = 16'h0077;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("to_valid", 32'(bus_valid), 32'd1);
      check("to_no_done", 32'(done), 32'd0);
      step();
    end
    check("to_valid_drop", 32'(bus_valid), 32'd0);
    check("to_done", 32'(done), 32'd1);
    check("to_error", 32'(error), 32'd1);
    check("to_rdata_kept", 32'(rdata), 32'hBEEF);
    step();
    check("to_idle_done", 32'(done), 32'd0);
    check("to_idle_error", 32'(error), 32'd0);
    check("to_idle_ready", 32'(req_ready), 32'd1);

    // Bus error on a load leaves rdata unchanged
    bus_ready = 1'b1; bus_err = 1'b1; bus_rdata = 16'hDEAD;
    req_valid = 1'b1; req_write = 1'b0; addr = 16'h0050;
    step();
    req_valid = 1'b0;
    check("be_valid", 32'(bus_valid), 32'd1);
    step();
    bus_err = 1'b0; bus_ready = 1'b0;
    check("be_done", 32'(done), 32'd1);
    check("be_error", 32'(error), 32'd1);
    check("be_rdata_kept", 32'(rdata), 32'hBEEF);
    step();

    // Back-to-back: request during BUS ignored, request during DONE accepted
    req_valid = 1'b1; req_write = 1'b0; addr = 16'h0100;
    step();
    addr = 16'h0200;
    check("bb_addr1", 32'(bus_addr), 32'h0100);
    step();
    check("bb_ignored", 32'(bus_addr), 32'h0100);
    check("bb_busy", 32'(busy), 32'd1);
    bus_ready = 1'b1; bus_rdata = 16'h5555;
    step();
    bus_ready = 1'b0;
    check("bb_done1", 32'(done), 32'd1);
    check("bb_rdata1", 32'(rdata), 32'h5555);
    check("bb_ready_done", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0; bus_ready = 1'b1; bus_rdata = 16'h6666;
    check("bb_valid2", 32'(bus_valid), 32'd1);
    check("bb_addr2", 32'(bus_addr), 32'h0200);
    check("bb_done_clear", 32'(done), 32'd0);
    step();
    bus_ready = 1'b0;
    check("bb_done2", 32'(done), 32'd1);
    check("bb_rdata2", 32'(rdata), 32'h6666);
    step();

    // Reset held three cycles during BUS aborts the transaction
    req_valid = 1'b1; req_write = 1'b1; addr = 16'h0300; wdata = 16'hABCD;
    step();
    req_valid = 1'b0;
    check("ab_valid", 32'(bus_valid), 32'd1);
    rst = 1'b1;
    step();
    check("ab_valid_drop", 32'(bus_valid), 32'd0);
    check("ab_no_done0", 32'(done), 32'd0);
    step(); step();
    rst = 1'b0;
    check("ab_ready", 32'(req_ready), 32'd1);
    check("ab_rdata", 32'(rdata), 32'h0);
    check("ab_addr", 32'(bus_addr), 32'h0);
    check("ab_we", 32'(bus_we), 32'd0);
    step();
    check("ab_no_done", 32'(done), 32'd0);
    check("ab_still_idle", 32'(bus_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
